// File: rtl/breadboard_sweeper_if.sv
// Row handshake between the sweeper and its downstream consumer.
interface breadboard_sweeper_if;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned F_W    = 10;
    localparam int unsigned ONES_W = 4;

    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic [F_W-1:0]    out_f;
    logic [ONES_W-1:0] out_ones;

    modport master (
        output out_valid,
        output out_idx,
        output out_f,
        output out_ones,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_f,
        input  out_ones,
        output out_ready
    );
endinterface

// File: rtl/breadboard_sweeper.sv
// Walks {w,x,y,z} through 0..LAST, lets the Breadboard settle, captures f and
// hands each row downstream with its index and popcount.
module breadboard_sweeper #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned LAST   = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        w,
    output logic                        x,
    output logic                        y,
    output logic                        z,
    input  logic [9:0]                  f,
    breadboard_sweeper_if.master        out_if,
    output logic                        busy,
    output logic                        done
);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned F_W    = 10;
    localparam int unsigned ONES_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic [IDX_W-1:0]    oidx_q, oidx_d;
    logic [F_W-1:0]      of_q, of_d;
    logic [ONES_W-1:0]   ones_q, ones_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Number of set bits in a captured row (max 10 fits in 4 bits).
    function automatic logic [ONES_W-1:0] popcount(input logic [F_W-1:0] v);
        logic [ONES_W-1:0] n;
        n = '0;
        for (int i = 0; i < int'(F_W); i++) begin
            n = n + ONES_W'(v[i]);
        end
        return n;
    endfunction

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            oidx_q  <= '0;
            of_q    <= '0;
            ones_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            oidx_q  <= oidx_d;
            of_q    <= of_d;
            ones_q  <= ones_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition fires.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        oidx_d  = oidx_q;
        of_d    = of_q;
        ones_d  = ones_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    of_d    = f;
                    ones_d  = popcount(f);
                    oidx_d  = idx_q;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (valid_q && out_if.out_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == IDX_W'(LAST)) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = '0;
                        state_d = DRIVE;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Stimulus is the index register itself, so it is glitch-free and registered.
    assign w = idx_q[3];
    assign x = idx_q[2];
    assign y = idx_q[1];
    assign z = idx_q[0];

    assign out_if.out_valid = valid_q;
    assign out_if.out_idx   = oidx_q;
    assign out_if.out_f     = of_q;
    assign out_if.out_ones  = ones_q;
    assign busy             = busy_q;
    assign done             = done_q;
endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed/randomized bench for breadboard_sweeper against a timing-schedule model.
module tb_breadboard_sweeper;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_v [3];
    logic       ready_v [3];
    logic [9:0] tt [16];

    int checks = 0;
    int errors = 0;

    logic       m_valid [3];
    logic       m_busy  [3];
    logic       m_done  [3];
    logic [3:0] m_idx   [3];
    logic [3:0] m_ones  [3];
    logic [3:0] m_stim  [3];
    logic [9:0] m_f     [3];

    always #5 clk = ~clk;

    // Three instances: defaults, SETTLE=1/LAST=3, SETTLE=5; each fed by a stand-in Breadboard table.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        breadboard_sweeper_if bus ();
        logic       w, x, y, z, busy, done;
        logic [9:0] f;

        assign f             = tt[{w, x, y, z}];
        assign bus.out_ready = ready_v[g];

        breadboard_sweeper #(
            .SETTLE(g == 0 ? 2 : (g == 1 ? 1 : 5)),
            .LAST  (g == 1 ? 3 : 15)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_v[g]),
            .w     (w),
            .x     (x),
            .y     (y),
            .z     (z),
            .f     (f),
            .out_if(bus),
            .busy  (busy),
            .done  (done)
        );

        assign m_valid[g] = bus.out_valid;
        assign m_idx[g]   = bus.out_idx;
        assign m_f[g]     = bus.out_f;
        assign m_ones[g]  = bus.out_ones;
        assign m_busy[g]  = busy;
        assign m_done[g]  = done;
        assign m_stim[g]  = {w, x, y, z};
    end

    // Row schedule of the reference model: drive start, capture and accept edges.
    int st [16];
    int cp [16];
    int ac [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input int sel);
        chk("rst_valid", 32'(m_valid[sel]), 0);
        chk("rst_idx",   32'(m_idx[sel]),   0);
        chk("rst_f",     32'(m_f[sel]),     0);
        chk("rst_ones",  32'(m_ones[sel]),  0);
        chk("rst_busy",  32'(m_busy[sel]),  0);
        chk("rst_done",  32'(m_done[sel]),  0);
        chk("rst_stim",  32'(m_stim[sel]),  0);
    endtask

    task automatic randomize_table();
        for (int i = 0; i < 16; i++) tt[i] = 10'($urandom);
        tt[0]  = 10'b0000000001;
        tt[15] = 10'b0010001011;
    endtask

    // One sweep on instance sel; bp_row stalls for bp_len cycles, rnd adds random
    // stalls on every row, spam pulses start mid-sweep, rst_row aborts with reset.
    task automatic run_sweep(input int sel, input int s, input int last, input int bp_row,
                             input int bp_len, input bit rnd, input bit spam, input int rst_row);
        int t;
        int last_acc;
        int dones;
        int ex;
        int e_valid, e_stim, e_row;
        bit stall, drv;

        t = 0;
        for (int k = 0; k <= last; k++) begin
            ex    = (k == bp_row) ? bp_len : (rnd ? int'($urandom_range(0, 3)) : 0);
            st[k] = t;
            cp[k] = t + s;
            ac[k] = cp[k] + 1 + ex;
            t     = ac[k];
        end
        last_acc = ac[last];
        dones    = 0;

        start_v[sel] = 1'b1;
        ready_v[sel] = 1'b1;
        tick();                 // E0
        start_v[sel] = 1'b0;

        for (int n = 0; n <= last_acc + 2; n++) begin
            e_valid = 0;
            e_row   = 0;
            e_stim  = (n == last_acc) ? last : 0;
            stall   = 1'b0;
            drv     = 1'b0;
            for (int k = 0; k <= last; k++) begin
                if (n >= st[k] && n < ac[k]) begin
                    e_stim = k;
                    if (n >= cp[k]) begin
                        e_valid = 1;
                        e_row   = k;
                        if (n < ac[k] - 1) stall = 1'b1;
                    end else begin
                        drv = 1'b1;
                    end
                end
            end

            chk("valid", 32'(m_valid[sel]), 32'(e_valid));
            chk("busy",  32'(m_busy[sel]),  32'(n <= last_acc));
            chk("done",  32'(m_done[sel]),  32'(n == last_acc));
            chk("stim",  32'(m_stim[sel]),  32'(e_stim));
            if (e_valid != 0) begin
                chk("idx",      32'(m_idx[sel]),  32'(e_row));
                chk("f",        32'(m_f[sel]),    32'(tt[e_row]));
                chk("ones",     32'(m_ones[sel]), 32'($countones(tt[e_row])));
                chk("ones_vs_f", 32'(m_ones[sel]), 32'($countones(m_f[sel])));
            end
            if (m_done[sel] === 1'b1) dones++;

            if (rst_row >= 0 && n == st[rst_row]) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk_zero(sel);
                tick();
                chk_zero(sel);
                return;
            end

            ready_v[sel] = stall ? 1'b0 : (drv ? 1'($urandom_range(0, 1)) : 1'b1);
            start_v[sel] = spam && ((n == cp[3]) || (last >= 10 && n == st[10]) || (n == last_acc));
            tick();
        end
        start_v[sel] = 1'b0;
        chk("done_pulses", 32'(dones), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            ready_v[i] = 1'b0;
        end
        randomize_table();
        tick();
        tick();
        for (int i = 0; i < 3; i++) chk_zero(i);
        rst_n = 1'b1;
        tick();

        run_sweep(0, 2, 15, -1, 0, 1'b0, 1'b1, -1);   // defaults, start pulses mid-sweep and in DONE
        tick();
        run_sweep(0, 2, 15, 5, 7, 1'b0, 1'b0, -1);    // backpressure on row 5
        tick();
        run_sweep(0, 2, 15, -1, 0, 1'b0, 1'b0, 9);    // reset during DRIVE of row 9
        randomize_table();
        run_sweep(0, 2, 15, -1, 0, 1'b1, 1'b0, -1);   // restart from 0 with random stalls
        tick();
        run_sweep(1, 1, 3, -1, 0, 1'b0, 1'b0, -1);    // SETTLE=1, LAST=3
        tick();
        run_sweep(2, 5, 15, -1, 0, 1'b0, 1'b0, -1);   // SETTLE=5
        tick();
        run_sweep(2, 5, 15, -1, 0, 1'b1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/breadboard_sweeper.md
# breadboard_sweeper

Sequential stimulus-and-capture stage that sits directly upstream of the Breadboard stage (4-input, 10-output combinational truth-table block) and consumes its outputs. On `start` it drives w,x,y,z through index 0..LAST (w = MSB). For each index it waits a settle interval, then captures the 10 function outputs f0..f9. Each captured row is presented downstream on a valid/ready handshake together with its index and a population count.

## Interface
- `SETTLE`, default 2: cycles w,x,y,z are held before f is sampled; legal range 1..15.
- `LAST`, default 15: final index of the sweep; legal range 0..15.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a sweep; sampled only in IDLE.
- `w`, `x`, `y`, `z`  out  1 each  stimulus to Breadboard; {w,x,y,z} = current index.
- `f`  in  10  Breadboard outputs; f[0]=f0 … f[9]=f9.
- `out_valid`  out  1  captured row available.
- `out_ready`  in  1  downstream accepts row.
- `out_idx`  out  4  index of captured row.
- `out_f`  out  10  captured f vector.
- `out_ones`  out  4  popcount of `out_f`, 0..10.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the final row is accepted.

## Operation
- States: IDLE, DRIVE, HOLD, DONE.
- **IDLE**
  - {w,x,y,z} = 0.
  - `start`=1 → DRIVE with index 0 and settle counter 0.
- **DRIVE**
  - {w,x,y,z} = index; counter increments each cycle.
  - On the edge ending the SETTLE-th DRIVE cycle:
    - capture `out_f` ← f and `out_ones` ← popcount(f);
    - set `out_idx` ← index and `out_valid` ← 1;
    - move to HOLD.
- **HOLD**
  - `out_valid`=1; stimulus held.
  - `out_f`, `out_ones` and `out_idx` stay stable until the handshake.
  - On an edge with `out_valid` & `out_ready`:
    - `out_valid` ← 0;
    - if index = LAST → DONE;
    - else index ← index+1, counter ← 0 → DRIVE.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE.
- `start` is ignored outside IDLE, including in DONE.
- Index is a 4-bit unsigned counter. It never wraps within a sweep, because the sweep terminates at LAST ≤ 15.
- Popcount uses a 4-bit result; the maximum is 10.
- Outputs are never driven from `f` combinationally. `out_f` changes only at capture.

## Timing
- Reset (`rst_n`=0 at an edge), from any state including mid-sweep:
  - state → IDLE;
  - w, x, y, z, `out_valid`, `out_idx`, `out_f`, `out_ones`, `busy`, `done` all → 0;
  - index and counter → 0;
  - an in-flight row is discarded.
- Label edges: E0 = edge where `start` is sampled in IDLE. Each row occupies SETTLE DRIVE cycles plus at least 1 HOLD cycle.
- Row k (k = 0..LAST):
  - with `out_ready` held at 1, `out_valid` rises after edge E((SETTLE+1)·k + SETTLE) and is accepted at the next edge;
  - with default parameters, `out_valid` rises after E(3k+2) and is accepted at E(3k+3).
- Defaults with `out_ready`=1 throughout:
  - last accept at E48;
  - `done`=1 in the cycle after E48;
  - IDLE (`busy`=0) after E49.
- Backpressure: while `out_ready`=0, stay in HOLD indefinitely with all outputs frozen. The next index is not driven until acceptance.
- `out_ready` asserted while `out_valid`=0 has no effect.

## Test plan
- Bench: instantiate with defaults, wired to the Breadboard stage; `out_ready`=1; pulse `start`.
  - Row 0: `out_idx`=0, `out_f`=10'b0000000001, `out_ones`=1.
  - Row 15: `out_idx`=15, `out_f`=10'b0010001011, `out_ones`=4.
  - Rows are accepted at E3, E6, …, E48; `done` is high only in the cycle after E48; `busy` falls after E49.
- Backpressure:
  - Drive `out_ready`=0 for 7 cycles at row 5.
  - Required: `out_valid`, `out_idx`=5, `out_f` and {w,x,y,z}=4'b0101 all stable throughout.
  - Row 6 is driven only after acceptance.
  - Total sweep length grows by exactly 7 cycles.
- Reset mid-sweep:
  - Assert `rst_n`=0 for 1 edge during DRIVE of row 9.
  - Required: all outputs 0 the next cycle and state IDLE.
  - A new `start` restarts at index 0.
- `start` during the sweep:
  - Pulse `start` at rows 3, 10 and in the DONE cycle.
  - Required: no restart, no change to the row sequence, and exactly one `done` pulse.
- Parameter sweep:
  - Run with SETTLE=1, LAST=3.
  - Required: rows accepted at E2, E4, E6, E8; `done` in the cycle after E8.
  - Run with SETTLE=5.
  - Required: row 0 `out_valid` rises after E5.
  - In both cases, `out_ones` equals the popcount of `out_f` on every row.
